// File: rtl/wspr_tx_sequencer_pkg.sv
// Shared types, sizes and the tone mapping helper for the WSPR transmit sequencer.
package wspr_pkg;

    localparam int NUM_SYMBOLS = 162;
    localparam int ADDR_W      = 8;
    localparam int FREQ_W      = 32;
    localparam int PER_W       = 32;

    typedef logic [1:0] wspr_sym_t;

    typedef enum logic [1:0] {
        IDLE,
        PREFETCH,
        LOAD,
        HOLD
    } tx_state_e;

    // base + sym*step without a multiplier: the symbol is only 2 bits, so
    // one shifted and one plain copy of step cover every tone. Wraps mod 2^FREQ_W.
    function automatic logic [FREQ_W-1:0] tone_freq(
        input logic [FREQ_W-1:0] base,
        input logic [FREQ_W-1:0] step,
        input wspr_sym_t         sym
    );
        logic [FREQ_W-1:0] w_two;
        logic [FREQ_W-1:0] w_one;
        w_two = sym[1] ? (step << 1) : '0;
        w_one = sym[0] ? step : '0;
        return base + w_two + w_one;
    endfunction

endpackage

// File: rtl/wspr_tx_sequencer_if.sv
// Bundle between the sequencer, the config/symbol-buffer side and the NCO side.
interface wspr_tx_sequencer_if #(
    parameter int ADDR_W = wspr_pkg::ADDR_W,
    parameter int FREQ_W = wspr_pkg::FREQ_W,
    parameter int PER_W  = wspr_pkg::PER_W
);
    import wspr_pkg::*;

    logic              io_start;
    logic              io_abort;
    logic              io_cfg_ready;
    logic [PER_W-1:0]  io_period_cycles;
    logic [FREQ_W-1:0] io_base_freq;
    logic [FREQ_W-1:0] io_tone_step;
    logic [ADDR_W-1:0] io_sym_addr;
    wspr_sym_t         io_sym_data;
    logic [FREQ_W-1:0] io_freq_word;
    wspr_sym_t         io_bit_out;
    logic              io_rf_en;
    logic              io_sym_strobe;
    logic              io_busy;
    logic              io_done;

    modport master (
        input  io_start, io_abort, io_cfg_ready, io_period_cycles,
               io_base_freq, io_tone_step, io_sym_data,
        output io_sym_addr, io_freq_word, io_bit_out, io_rf_en,
               io_sym_strobe, io_busy, io_done
    );

    modport slave (
        output io_start, io_abort, io_cfg_ready, io_period_cycles,
               io_base_freq, io_tone_step, io_sym_data,
        input  io_sym_addr, io_freq_word, io_bit_out, io_rf_en,
               io_sym_strobe, io_busy, io_done
    );

endinterface

// File: rtl/wspr_tx_sequencer_symbol_timer.sv
// Symbol period counter: holds the per-transmission period and flags its expiry.
module wspr_symbol_timer #(
    parameter int PER_W = wspr_pkg::PER_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [PER_W-1:0] i_period,
    input  logic             i_clear,
    output logic             o_expired
);
    logic [PER_W-1:0] r_period;
    logic [PER_W-1:0] r_count;

    // Capture the period at transmission start; zero is clamped to one so a symbol never degenerates.
    always_ff @(posedge clock) begin
        if (i_load) begin
            r_period <= (i_period == '0) ? PER_W'(1) : i_period;
        end
    end

    // Count cycles since the last symbol boundary; the controller clears it on each boundary.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + PER_W'(1);
        end
    end

    assign o_expired = (r_count == r_period);

endmodule

// File: rtl/wspr_tx_sequencer.sv
// WSPR transmit scheduler: walks the symbol buffer and drives one NCO tone per symbol period.
module wspr_tx_sequencer #(
    parameter int NUM_SYMBOLS = wspr_pkg::NUM_SYMBOLS,
    parameter int ADDR_W      = wspr_pkg::ADDR_W,
    parameter int FREQ_W      = wspr_pkg::FREQ_W,
    parameter int PER_W       = wspr_pkg::PER_W
) (
    input logic                 clock,
    input logic                 reset,
    wspr_tx_sequencer_if.master bus
);
    import wspr_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SYMBOLS - 1);
    localparam logic [ADDR_W-1:0] END_IDX  = ADDR_W'(NUM_SYMBOLS);

    tx_state_e         r_state;
    logic              r_start_d;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_sym_addr;
    logic [FREQ_W-1:0] r_freq;
    logic [FREQ_W-1:0] r_base;
    logic [FREQ_W-1:0] r_step;
    wspr_sym_t         r_bit;
    logic              r_rf_en;
    logic              r_strobe;
    logic              r_busy;
    logic              r_done;

    logic w_start_edge;
    logic w_accept;
    logic w_aborting;
    logic w_clear;
    logic w_expired;

    assign w_start_edge = bus.io_start & ~r_start_d;
    assign w_aborting   = (r_state != IDLE) && bus.io_abort;
    assign w_accept     = (r_state == IDLE) && w_start_edge && bus.io_cfg_ready && !bus.io_abort;
    // The counter reads 0 during every LOAD cycle, so LOAD + P HOLD cycles give P+1 per symbol.
    assign w_clear      = (r_state == PREFETCH) || ((r_state == HOLD) && w_expired);

    wspr_symbol_timer #(
        .PER_W (PER_W)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .i_load    (w_accept),
        .i_period  (bus.io_period_cycles),
        .i_clear   (w_clear),
        .o_expired (w_expired)
    );

    // Sequencing FSM with all outputs registered. The index runs one past the last
    // symbol so the final tone stays on air a full period; that terminal LOAD then
    // ends the transmission exactly where the next strobe would have appeared.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_start_d  <= 1'b1;
            r_idx      <= '0;
            r_sym_addr <= '0;
            r_freq     <= '0;
            r_bit      <= '0;
            r_rf_en    <= 1'b0;
            r_strobe   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_start_d <= bus.io_start;
            r_strobe  <= 1'b0;
            r_done    <= 1'b0;
            if (w_aborting) begin
                r_state    <= IDLE;
                r_rf_en    <= 1'b0;
                r_busy     <= 1'b0;
                r_bit      <= '0;
                r_sym_addr <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_state    <= PREFETCH;
                            r_base     <= bus.io_base_freq;
                            r_step     <= bus.io_tone_step;
                            r_sym_addr <= '0;
                            r_idx      <= '0;
                            r_busy     <= 1'b1;
                        end
                    end
                    PREFETCH: begin
                        r_state <= LOAD;
                    end
                    LOAD: begin
                        if (r_idx == END_IDX) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_rf_en <= 1'b0;
                            r_bit   <= '0;
                        end else begin
                            r_state  <= HOLD;
                            r_bit    <= bus.io_sym_data;
                            r_freq   <= tone_freq(r_base, r_step, bus.io_sym_data);
                            r_strobe <= 1'b1;
                            r_rf_en  <= 1'b1;
                            if (r_idx != LAST_IDX) begin
                                r_sym_addr <= r_idx + ADDR_W'(1);
                            end
                        end
                    end
                    HOLD: begin
                        if (w_expired) begin
                            r_idx   <= r_idx + ADDR_W'(1);
                            r_state <= LOAD;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.io_sym_addr   = r_sym_addr;
    assign bus.io_freq_word  = r_freq;
    assign bus.io_bit_out    = r_bit;
    assign bus.io_rf_en      = r_rf_en;
    assign bus.io_sym_strobe = r_strobe;
    assign bus.io_busy       = r_busy;
    assign bus.io_done       = r_done;

endmodule

// File: tb/tb_wspr_tx_sequencer.sv
// Scoreboard bench for wspr_tx_sequencer: an event-list model of each transmission
// feeds expected strobes/done into queues that a negedge monitor consumes.
module tb_wspr_tx_sequencer;

    localparam int NSYM = 162;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wspr_tx_sequencer_if bus ();

    wspr_tx_sequencer dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic [31:0] freq;
        logic [1:0]  sym;
    } exp_t;

    exp_t       exp_sym[$];
    exp_t       exp_done[$];
    logic [1:0] mem [NSYM];

    int   cyc      = 0;
    int   errors   = 0;
    int   checks   = 0;
    int   max_addr = 0;
    int   m_end    = 0;
    int   m_s      = 0;
    int   m_pe     = 1;
    logic m_prev_start = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Symbol buffer with one cycle of read latency.
    always @(posedge clk) begin
        int a;
        a = int'(bus.io_sym_addr);
        bus.io_sym_data <= (a < NSYM) ? mem[a] : 2'b00;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.io_sym_addr, bus.io_freq_word, bus.io_bit_out, bus.io_rf_en,
                    bus.io_sym_strobe, bus.io_busy, bus.io_done});
    endfunction

    // Monitor: whenever the DUT presents a strobe or done, pop the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (int'(bus.io_sym_addr) > max_addr) max_addr = int'(bus.io_sym_addr);
        if (bus.io_sym_strobe) begin
            chk("strobe_expected", 64'(exp_sym.size() != 0), 64'd1);
            if (exp_sym.size() != 0) begin
                e = exp_sym.pop_front();
                chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
                chk("freq_word", 64'(bus.io_freq_word), 64'(e.freq));
                chk("bit_out", 64'(bus.io_bit_out), 64'(e.sym));
                chk("rf_en_on", 64'(bus.io_rf_en), 64'd1);
                chk("busy_on", 64'(bus.io_busy), 64'd1);
            end
        end
        if (bus.io_done) begin
            chk("done_expected", 64'(exp_done.size() != 0), 64'd1);
            if (exp_done.size() != 0) begin
                e = exp_done.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("done_busy", 64'(bus.io_busy), 64'd0);
                chk("done_rf_en", 64'(bus.io_rf_en), 64'd0);
                chk("done_bit_out", 64'(bus.io_bit_out), 64'd0);
                chk("done_freq_hold", 64'(bus.io_freq_word), 64'(e.freq));
                chk("done_addr", 64'(bus.io_sym_addr), 64'(NSYM - 1));
            end
        end
    end

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < NSYM; i++) mem[i] = rnd ? 2'($urandom_range(0, 3)) : 2'(i % 4);
    endtask

    // Issue a one-cycle start pulse; if the model says it is accepted, queue the whole transmission.
    task automatic do_start(input logic [31:0] p, input logic [31:0] base, input logic [31:0] step);
        int s;
        int pe;
        bit accept;
        @(negedge clk);
        s = cyc;
        bus.io_cfg_ready     = 1'b1;
        bus.io_period_cycles = p;
        bus.io_base_freq     = base;
        bus.io_tone_step     = step;
        bus.io_start         = 1'b1;
        accept = !m_prev_start && (s >= m_end) && !bus.io_abort;
        m_prev_start = 1'b1;
        if (accept) begin
            pe = (p == 0) ? 1 : int'(p);
            for (int i = 0; i < NSYM; i++)
                exp_sym.push_back('{s + 3 + i * (pe + 1), base + 32'(mem[i]) * step, mem[i]});
            exp_done.push_back('{s + 3 + NSYM * (pe + 1), base + 32'(mem[NSYM-1]) * step, 2'b00});
            m_s   = s;
            m_pe  = pe;
            m_end = s + 3 + NSYM * (pe + 1);
        end
        @(negedge clk);
        bus.io_start = 1'b0;
        m_prev_start = 1'b0;
        if (accept) begin
            chk("start_busy", 64'(bus.io_busy), 64'd1);
            chk("start_addr", 64'(bus.io_sym_addr), 64'd0);
        end
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((exp_sym.size() + exp_done.size()) != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_sym.size() + exp_done.size()), 64'd0);
        exp_sym.delete();
        exp_done.delete();
        @(negedge clk);
    endtask

    // Abort off cycles into symbol k of the running transmission.
    task automatic abort_at(input int k, input int off);
        int target;
        int n = 0;
        target = m_s + 3 + k * (m_pe + 1) + off;
        while (cyc < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached", 64'(cyc), 64'(target));
        bus.io_abort = 1'b1;
        while (exp_sym.size() != 0 && exp_sym[$].cyc > cyc) void'(exp_sym.pop_back());
        exp_done.delete();
        m_end = cyc + 1;
        @(negedge clk);
        bus.io_abort = 1'b0;
        chk("abort_rf_en", 64'(bus.io_rf_en), 64'd0);
        chk("abort_busy", 64'(bus.io_busy), 64'd0);
        chk("abort_bit_out", 64'(bus.io_bit_out), 64'd0);
        chk("abort_addr", 64'(bus.io_sym_addr), 64'd0);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.io_start         = 1'b1;
        bus.io_abort         = 1'b0;
        bus.io_cfg_ready     = 1'b1;
        bus.io_period_cycles = 32'd5;
        bus.io_base_freq     = '0;
        bus.io_tone_step     = '0;
        fill_mem(1'b0);

        // Reset with start held high: no transmission after release.
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("post_reset_idle", outs(), 64'd0);
        end
        bus.io_start = 1'b0;
        m_prev_start = 1'b0;
        @(negedge clk);

        // Normal run: sym[i] = i%4, P = 3.
        do_start(32'd3, 32'h1000_0000, 32'h10);
        wait_drain(1000);

        // Start edge with cfg_ready low is dropped; raising cfg_ready under a held start does nothing.
        @(negedge clk);
        bus.io_cfg_ready = 1'b0;
        bus.io_start     = 1'b1;
        m_prev_start     = 1'b1;
        @(negedge clk);
        bus.io_cfg_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("no_start_busy", 64'(bus.io_busy), 64'd0);
        end
        bus.io_start = 1'b0;
        m_prev_start = 1'b0;

        // P = 0 clamps to 1.
        fill_mem(1'b1);
        do_start(32'd0, $urandom, $urandom);
        wait_drain(500);

        // Abort at symbol 50, then a random abort inside a symbol, then a full run.
        fill_mem(1'b1);
        do_start(32'd2, $urandom, $urandom);
        abort_at(50, 0);
        repeat (20) @(negedge clk);
        do_start(32'd1, $urandom, $urandom);
        abort_at($urandom_range(1, 160), $urandom_range(0, 1));
        repeat (20) @(negedge clk);
        do_start(32'd1, $urandom, $urandom);
        wait_drain(500);

        // Reset mid-transmission behaves like abort.
        fill_mem(1'b1);
        do_start(32'd1, $urandom, $urandom);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        while (exp_sym.size() != 0 && exp_sym[$].cyc > cyc) void'(exp_sym.pop_back());
        exp_done.delete();
        @(negedge clk);
        chk("midrun_reset_outputs", outs(), 64'd0);
        rst   = 1'b0;
        m_end = cyc;
        repeat (5) @(negedge clk);

        // Wrap of the tuning word, and config changes plus a start pulse while busy.
        fill_mem(1'b1);
        mem[0]      = 2'd3;
        mem[NSYM-1] = 2'd3;
        do_start(32'd2, 32'hFFFF_FFF0, 32'h10);
        repeat (30) @(negedge clk);
        do_start(32'd0, 32'h0, 32'h1);
        wait_drain(1000);

        // Random configurations.
        repeat (2) begin
            fill_mem(1'b1);
            do_start($urandom_range(0, 3), $urandom, $urandom);
            wait_drain(1000);
        end

        chk("sym_addr_bound", 64'(max_addr > NSYM - 1), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wspr_tx_sequencer.md
Name: wspr_tx_sequencer

Overview:
Transmit scheduler that walks the 162-entry WSPR channel-symbol buffer and drives the RF NCO with one tone per symbol period. It sits between the config/encoder stage, which fills the symbol buffer and raises cfg_ready, and the NCO/RF output stage, which consumes freq_word and rf_en. It owns symbol timing, buffer read addressing, tone-to-frequency mapping, and start/abort/done sequencing.

Parameters:
NUM_SYMBOLS, 162, symbols per transmission
ADDR_W, 8, symbol buffer address width
FREQ_W, 32, NCO tuning word width
PER_W, 32, symbol period counter width

Ports:
clock  in  1  single system clock
reset  in  1  synchronous, active-high reset
io_start  in  1  level; a rising edge requests a transmission
io_abort  in  1  level; when high, terminates the transmission immediately
io_cfg_ready  in  1  symbol buffer and config are valid
io_period_cycles  in  PER_W  symbol period minus 1, in clock cycles
io_base_freq  in  FREQ_W  tuning word for tone 0
io_tone_step  in  FREQ_W  tuning word per tone spacing
io_sym_addr  out  ADDR_W  symbol buffer read address
io_sym_data  in  2  buffer read data, valid 1 cycle after io_sym_addr
io_freq_word  out  FREQ_W  NCO tuning word
io_bit_out  out  2  current channel symbol
io_rf_en  out  1  RF output enable
io_sym_strobe  out  1  1-cycle pulse when a new symbol appears on the outputs
io_busy  out  1  transmission in progress
io_done  out  1  1-cycle pulse on normal completion

Behaviour:
- Reset: every output is 0 and the state is IDLE. The start-edge register resets to 1, so an io_start level held through reset does not trigger a transmission.
- States: IDLE, PREFETCH, LOAD, HOLD.
- IDLE -> PREFETCH when a rising edge of io_start occurs and io_cfg_ready = 1 in the same cycle.
  - On that transition, latch io_period_cycles (0 is clamped to 1), io_base_freq and io_tone_step. These inputs are ignored at all other times.
  - Drive sym_addr = 0, idx = 0 and busy = 1.
  - A start edge with cfg_ready = 0 is dropped; it is not queued.
- PREFETCH: lasts exactly 1 cycle, then goes to LOAD.
- LOAD: lasts 1 cycle.
  - Capture sym_data into bit_out.
  - Set freq_word = base + sym*step, computed modulo 2^FREQ_W as base + (sym[1] ? step<<1 : 0) + (sym[0] ? step : 0).
  - The registered outputs, sym_strobe and rf_en = 1 are visible in the following cycle.
  - Set sym_addr = idx+1 to prefetch the next symbol. Clear the period counter to 0.
- HOLD: the counter increments each cycle.
  - When counter == P and idx < NUM_SYMBOLS-1: increment idx and go to LOAD.
  - When counter == P and idx == NUM_SYMBOLS-1: go to IDLE with rf_en = 0, bit_out = 0 and a done pulse. busy falls in the same cycle done is high. freq_word holds its last value.
- Timing:
  - Strobe spacing is exactly P+1 cycles.
  - The first sym_strobe is 3 cycles after io_start is first sampled high.
  - done is 3 + NUM_SYMBOLS*(P+1) cycles after the start sample.
- Abort: io_abort high in any non-IDLE state forces IDLE on the next edge.
  - rf_en, busy, bit_out and sym_addr go to 0. No done pulse is issued.
  - Abort has priority over a simultaneous start, LOAD or final-symbol event.
- io_start edges while busy are ignored.
- Reset asserted mid-transmission behaves like abort, and the outputs return to their reset values.
- Buffer wrap: sym_addr never exceeds NUM_SYMBOLS-1. The prefetch in the last LOAD is suppressed, so sym_addr holds at 161.

Decomposition:
- Shared package wspr_pkg holds:
  - NUM_SYMBOLS = 162
  - typedef wspr_sym_t = logic [1:0]
  - the state enum tx_state_e {IDLE, PREFETCH, LOAD, HOLD}
  - FREQ_W and PER_W
- One natural sub-module: wspr_symbol_timer, the period counter with its latched, clamped period and a period-expired output.

Test Plan:
- Reset with io_start held high, then release reset -> no transmission; every output stays 0 for 20 cycles.
- Normal run: buffer sym[i] = i%4, P = 3, base = 0x1000_0000, step = 0x10, start pulse ->
  - 162 strobes spaced 4 cycles apart;
  - freq_word = 0x1000_0000 + (i%4)*0x10 and bit_out = i%4 on each strobe;
  - done at cycle 651 after start; busy and rf_en fall in that same cycle.
- cfg_ready = 0 with a start pulse -> busy stays 0. Raising cfg_ready while start is still held -> still no start until a new rising edge.
- Abort at symbol 50 -> rf_en = 0 on the next cycle and no done. A fresh start then begins again at sym_addr = 0.
- P = 0 -> clamped; strobe spacing 2 and done at 3 + 162*2 = 327 cycles.
- Change period/base/step and pulse start while busy -> no effect on the current run. base = 0xFFFF_FFF0, step = 0x10, sym = 3 -> freq_word wraps to 0x0000_0020.
